// File: rtl/ssd_pkg.sv
// Shared constants for the seven-segment TDM driver: glyph patterns, segment
// bit positions and a width helper.
package ssd_pkg;

    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;

    // Active-high patterns, bit order gfedcba
    localparam logic [6:0] GLYPH_BLANK = 7'b0000000;
    localparam logic [6:0] GLYPH_0     = 7'b0111111;
    localparam logic [6:0] GLYPH_1     = 7'b0000110;
    localparam logic [6:0] GLYPH_2     = 7'b1011011;
    localparam logic [6:0] GLYPH_3     = 7'b1001111;
    localparam logic [6:0] GLYPH_4     = 7'b1100110;
    localparam logic [6:0] GLYPH_5     = 7'b1101101;
    localparam logic [6:0] GLYPH_6     = 7'b1111101;
    localparam logic [6:0] GLYPH_7     = 7'b0000111;
    localparam logic [6:0] GLYPH_8     = 7'b1111111;
    localparam logic [6:0] GLYPH_9     = 7'b1101111;
    localparam logic [6:0] GLYPH_A     = 7'b1110111;
    localparam logic [6:0] GLYPH_B     = 7'b1111100;
    localparam logic [6:0] GLYPH_C     = 7'b0111001;
    localparam logic [6:0] GLYPH_D     = 7'b1011110;
    localparam logic [6:0] GLYPH_E     = 7'b1111001;
    localparam logic [6:0] GLYPH_F     = 7'b1110001;

    // Bits needed to count 0..n-1, never less than one so a single-digit
    // build still has a legal index register.
    function automatic int ssd_clog2(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/ssd_glyph_rom.sv
// Combinational nibble-to-segment decoder, active-high gfedcba output.
// Decimal mode blanks 10-15; the blank input overrides everything.
module ssd_glyph_rom
    import ssd_pkg::*;
(
    input  logic [3:0] value,
    input  logic       hex_mode,
    input  logic       blank,
    output logic [6:0] pattern
);

    always_comb begin
        pattern = GLYPH_BLANK;
        if (!blank && (hex_mode || (value < 4'd10))) begin
            case (value)
                4'h0:    pattern = GLYPH_0;
                4'h1:    pattern = GLYPH_1;
                4'h2:    pattern = GLYPH_2;
                4'h3:    pattern = GLYPH_3;
                4'h4:    pattern = GLYPH_4;
                4'h5:    pattern = GLYPH_5;
                4'h6:    pattern = GLYPH_6;
                4'h7:    pattern = GLYPH_7;
                4'h8:    pattern = GLYPH_8;
                4'h9:    pattern = GLYPH_9;
                4'hA:    pattern = GLYPH_A;
                4'hB:    pattern = GLYPH_B;
                4'hC:    pattern = GLYPH_C;
                4'hD:    pattern = GLYPH_D;
                4'hE:    pattern = GLYPH_E;
                default: pattern = GLYPH_F;
            endcase
        end
    end

endmodule

// File: rtl/ssd_tdm_driver.sv
// Time-multiplexed seven-segment driver: one digit per REFRESH_DIV-cycle slot,
// dead time at slot start, frame-coherent capture, all pins registered (1 cycle).
module ssd_tdm_driver
    import ssd_pkg::*;
#(
    parameter int N_DIGITS       = 4,
    parameter int REFRESH_DIV    = 100000,
    parameter int BLANK_CYCLES   = 16,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [4*N_DIGITS-1:0] digits,
    input  logic [N_DIGITS-1:0]   dp_in,
    input  logic                  hex_mode,
    input  logic                  lz_blank,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [N_DIGITS-1:0]   an,
    output logic                  frame_start
);

    localparam int IDX_W = ssd_clog2(N_DIGITS);
    localparam int CNT_W = ssd_clog2(REFRESH_DIV);

    localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0]    IDX_LAST = IDX_W'(N_DIGITS - 1);
    localparam logic [6:0]          SEG_OFF  = {7{SEG_ACTIVE_LOW}};
    localparam logic                DP_OFF   = SEG_ACTIVE_LOW;
    localparam logic [N_DIGITS-1:0] AN_OFF   = {N_DIGITS{AN_ACTIVE_LOW}};

    logic [CNT_W-1:0]      cnt;
    logic [IDX_W-1:0]      idx;
    logic [4*N_DIGITS-1:0] frame_digits;
    logic [N_DIGITS-1:0]   frame_dp;
    logic                  frame_hex;
    logic                  frame_lz;

    logic                  frame_edge;
    logic                  capture;
    logic [4*N_DIGITS-1:0] cur_digits;
    logic [N_DIGITS-1:0]   cur_dp;
    logic                  cur_hex;
    logic                  cur_lz;
    logic [N_DIGITS-1:0]   lead_zero;
    logic [N_DIGITS-1:0]   an_hot;
    logic [3:0]            sel_value;
    logic                  sel_dp;
    logic                  sel_lead;
    logic                  sel_blank;
    logic                  in_dead;
    logic [6:0]            pattern;

    assign frame_edge = (cnt == '0) && (idx == '0);
    assign capture    = !en || frame_edge;
    assign in_dead    = int'(cnt) < BLANK_CYCLES;

    // The capture cycle already sees the values being latched, so a frame
    // with no dead time still shows a coherent first digit.
    assign cur_digits = capture ? digits   : frame_digits;
    assign cur_dp     = capture ? dp_in    : frame_dp;
    assign cur_hex    = capture ? hex_mode : frame_hex;
    assign cur_lz     = capture ? lz_blank : frame_lz;

    // lead_zero[i]: digit i and every digit above it are zero
    always_comb begin
        lead_zero = '0;
        for (int i = 0; i < N_DIGITS; i++) begin
            lead_zero[i] = 1'b1;
            for (int j = i; j < N_DIGITS; j++) begin
                if (cur_digits[4*j +: 4] != 4'h0) begin
                    lead_zero[i] = 1'b0;
                end
            end
        end
    end

    always_comb begin
        sel_value = 4'h0;
        sel_dp    = 1'b0;
        sel_lead  = 1'b0;
        an_hot    = '0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (idx == IDX_W'(i)) begin
                sel_value = cur_digits[4*i +: 4];
                sel_dp    = cur_dp[i];
                sel_lead  = lead_zero[i];
                an_hot[i] = 1'b1;
            end
        end
    end

    assign sel_blank = cur_lz && sel_lead && (idx != '0);

    ssd_glyph_rom u_glyph_rom (
        .value    (sel_value),
        .hex_mode (cur_hex),
        .blank    (sel_blank),
        .pattern  (pattern)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            idx <= '0;
        end else if (!en) begin
            cnt <= '0;
            idx <= '0;
        end else if (cnt == CNT_LAST) begin
            cnt <= '0;
            idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_digits <= '0;
            frame_dp     <= '0;
            frame_hex    <= 1'b0;
            frame_lz     <= 1'b0;
        end else if (capture) begin
            frame_digits <= digits;
            frame_dp     <= dp_in;
            frame_hex    <= hex_mode;
            frame_lz     <= lz_blank;
        end
    end

    // XOR against the "off" pattern applies pin polarity in one step
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg         <= SEG_OFF;
            dp          <= DP_OFF;
            an          <= AN_OFF;
            frame_start <= 1'b0;
        end else begin
            frame_start <= en && frame_edge;
            if (!en || in_dead) begin
                seg <= SEG_OFF;
                dp  <= DP_OFF;
                an  <= AN_OFF;
            end else begin
                seg <= pattern ^ SEG_OFF;
                dp  <= sel_dp ^ DP_OFF;
                an  <= an_hot ^ AN_OFF;
            end
        end
    end

endmodule

// File: tb/tb_ssd_tdm_driver.sv
// Bench for ssd_tdm_driver: directed vector table, hand-written corner sequences
// and a randomized run against a slot/frame arithmetic reference model.
module tb_ssd_tdm_driver;

    localparam int N   = 4;
    localparam int DIV = 8;
    localparam int BLK = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [15:0] digits;
    logic [3:0]  dp_in;
    logic        hex_mode;
    logic        lz_blank;

    logic [6:0]  seg_a, seg_b;
    logic        dp_a, dp_b;
    logic [3:0]  an_a, an_b;
    logic        fs_a, fs_b;

    int total = 0;
    int bad   = 0;
    bit chk_on = 1'b0;

    always #5 clk = ~clk;

    ssd_tdm_driver #(.N_DIGITS(N), .REFRESH_DIV(DIV), .BLANK_CYCLES(BLK),
                     .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)) dut_a (
        .clk(clk), .rst(rst), .en(en), .digits(digits), .dp_in(dp_in),
        .hex_mode(hex_mode), .lz_blank(lz_blank),
        .seg(seg_a), .dp(dp_a), .an(an_a), .frame_start(fs_a));

    ssd_tdm_driver #(.N_DIGITS(N), .REFRESH_DIV(DIV), .BLANK_CYCLES(BLK),
                     .SEG_ACTIVE_LOW(1'b0), .AN_ACTIVE_LOW(1'b0)) dut_b (
        .clk(clk), .rst(rst), .en(en), .digits(digits), .dp_in(dp_in),
        .hex_mode(hex_mode), .lz_blank(lz_blank),
        .seg(seg_b), .dp(dp_b), .an(an_b), .frame_start(fs_b));

    // Reference glyphs, active-high gfedcba
    logic [6:0] ref_glyph [16] = '{
        7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
        7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
        7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
        7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001};

    // Reference model: k counts enabled cycles since the scan last restarted;
    // slot and in-slot position follow from plain division.
    int          k;
    logic [15:0] f_dig;
    logic [3:0]  f_dp;
    logic        f_hex, f_lz;
    logic [6:0]  e_seg;
    logic        e_dp;
    logic [3:0]  e_an;
    logic        e_fs;

    always @(posedge clk or posedge rst) begin : model
        int pos, slot, c;
        logic [15:0] fd;
        logic [3:0]  fdp, v;
        logic        fh, fl, blank;
        if (rst) begin
            k <= 0; e_seg <= 7'h0; e_dp <= 1'b0; e_an <= 4'h0; e_fs <= 1'b0;
            f_dig <= 16'h0; f_dp <= 4'h0; f_hex <= 1'b0; f_lz <= 1'b0;
        end else if (!en) begin
            k <= 0; e_seg <= 7'h0; e_dp <= 1'b0; e_an <= 4'h0; e_fs <= 1'b0;
        end else begin
            pos  = k % (DIV * N);
            fd   = (pos == 0) ? digits   : f_dig;
            fdp  = (pos == 0) ? dp_in    : f_dp;
            fh   = (pos == 0) ? hex_mode : f_hex;
            fl   = (pos == 0) ? lz_blank : f_lz;
            if (pos == 0) begin
                f_dig <= digits; f_dp <= dp_in; f_hex <= hex_mode; f_lz <= lz_blank;
            end
            slot = pos / DIV;
            c    = pos % DIV;
            e_fs <= (pos == 0);
            if (c < BLK) begin
                e_seg <= 7'h0; e_dp <= 1'b0; e_an <= 4'h0;
            end else begin
                v     = fd[slot*4 +: 4];
                blank = fl && (slot != 0) && ((fd >> (slot*4)) == 16'h0);
                e_seg <= (blank || (!fh && v > 4'd9)) ? 7'h0 : ref_glyph[v];
                e_dp  <= fdp[slot];
                e_an  <= 4'b0001 << slot;
            end
            k <= pos + 1;
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            total++;
            if (seg_a !== ~e_seg || dp_a !== ~e_dp || an_a !== ~e_an || fs_a !== e_fs) begin
                bad++;
                $display("FAIL model_lowpol t=%0t: seg=%b dp=%b an=%b fs=%b required seg=%b dp=%b an=%b fs=%b",
                         $time, seg_a, dp_a, an_a, fs_a, ~e_seg, ~e_dp, ~e_an, e_fs);
            end
            total++;
            if (seg_b !== e_seg || dp_b !== e_dp || an_b !== e_an || fs_b !== e_fs) begin
                bad++;
                $display("FAIL model_highpol t=%0t: seg=%b dp=%b an=%b fs=%b required seg=%b dp=%b an=%b fs=%b",
                         $time, seg_b, dp_b, an_b, fs_b, e_seg, e_dp, e_an, e_fs);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s t=%0t: got %0h required %0h", name, $time, act, exp);
        end
    endtask

    task automatic wait_fs();
        int n;
        n = 0;
        @(negedge clk);
        while (!fs_a && n < 200) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (!fs_a) begin
            bad++;
            $display("FAIL wait_frame_start t=%0t: got no pulse required pulse within 200 cycles", $time);
        end
    endtask

    typedef struct {
        logic [15:0] dig;
        logic [3:0]  dpi;
        logic        hex;
        logic        lz;
        int          slot;
        logic [6:0]  seg_exp;
        logic        dp_exp;
    } vec_t;

    vec_t vt[17];
    logic [3:0] an_samp [70];
    logic       fs_samp [70];
    logic [6:0] seg_samp2;

    initial begin
        int fs_cnt, fs_first, fs_second, off_left;
        vt[0]  = '{16'h1234, 4'b0000, 1'b0, 1'b0, 0, 7'b0011001, 1'b1};
        vt[1]  = '{16'h1234, 4'b0000, 1'b0, 1'b0, 1, 7'b0110000, 1'b1};
        vt[2]  = '{16'h1234, 4'b0000, 1'b0, 1'b0, 2, 7'b0100100, 1'b1};
        vt[3]  = '{16'h1234, 4'b0000, 1'b0, 1'b0, 3, 7'b1111001, 1'b1};
        vt[4]  = '{16'h00A5, 4'b0000, 1'b0, 1'b1, 3, 7'b1111111, 1'b1};
        vt[5]  = '{16'h00A5, 4'b0000, 1'b0, 1'b1, 2, 7'b1111111, 1'b1};
        vt[6]  = '{16'h00A5, 4'b0000, 1'b0, 1'b1, 1, 7'b1111111, 1'b1};
        vt[7]  = '{16'h00A5, 4'b0000, 1'b0, 1'b1, 0, 7'b0010010, 1'b1};
        vt[8]  = '{16'h00A5, 4'b0000, 1'b1, 1'b1, 1, 7'b0001000, 1'b1};
        vt[9]  = '{16'h00A5, 4'b0000, 1'b1, 1'b1, 2, 7'b1111111, 1'b1};
        vt[10] = '{16'h0000, 4'b0100, 1'b0, 1'b1, 0, 7'b1000000, 1'b1};
        vt[11] = '{16'h0000, 4'b0100, 1'b0, 1'b1, 2, 7'b1111111, 1'b0};
        vt[12] = '{16'h0102, 4'b0000, 1'b0, 1'b1, 1, 7'b1000000, 1'b1};
        vt[13] = '{16'h0102, 4'b0000, 1'b0, 1'b1, 3, 7'b1111111, 1'b1};
        vt[14] = '{16'hF0E0, 4'b0000, 1'b1, 1'b1, 3, 7'b0001110, 1'b1};
        vt[15] = '{16'hF0E0, 4'b0000, 1'b1, 1'b1, 1, 7'b0000110, 1'b1};
        vt[16] = '{16'h1234, 4'b1000, 1'b0, 1'b0, 3, 7'b1111001, 1'b0};

        rst = 1'b1; en = 1'b1; digits = 16'h1234; dp_in = 4'h0;
        hex_mode = 1'b0; lz_blank = 1'b0;
        repeat (2) @(negedge clk);
        chk_on = 1'b1;
        check("reset_seg", {25'h0, seg_a}, 32'h7F);
        check("reset_dp", {31'h0, dp_a}, 32'h1);
        check("reset_an", {28'h0, an_a}, 32'hF);
        check("reset_fs", {31'h0, fs_a}, 32'h0);
        check("reset_highpol", {20'h0, seg_b, dp_b, an_b}, 32'h0);

        // Scan order and frame period straight out of reset
        rst = 1'b0;
        for (int i = 0; i < 70; i++) begin
            @(negedge clk);
            an_samp[i] = an_a;
            fs_samp[i] = fs_a;
            if (i == 2) seg_samp2 = seg_a;
        end
        check("scan_fs_first", {31'h0, fs_samp[0]}, 32'h1);
        check("scan_dead0", {24'h0, an_samp[0], an_samp[1]}, 32'hFF);
        check("scan_digit0_an", {28'h0, an_samp[2]}, 32'hE);
        check("scan_digit0_seg", {25'h0, seg_samp2}, 32'h19);
        check("scan_digit0_end", {28'h0, an_samp[7]}, 32'hE);
        check("scan_dead1", {28'h0, an_samp[8]}, 32'hF);
        check("scan_digit1_an", {28'h0, an_samp[10]}, 32'hD);
        check("scan_digit3_an", {28'h0, an_samp[31]}, 32'h7);
        check("scan_wrap_an", {28'h0, an_samp[34]}, 32'hE);
        fs_cnt = 0; fs_first = -1; fs_second = -1;
        for (int i = 0; i < 64; i++) begin
            if (fs_samp[i]) begin
                fs_cnt++;
                if (fs_first < 0) fs_first = i;
                else if (fs_second < 0) fs_second = i;
            end
        end
        check("fs_count_64", fs_cnt, 2);
        check("fs_period", fs_second - fs_first, 32);

        for (int i = 0; i < 17; i++) begin
            digits = vt[i].dig; dp_in = vt[i].dpi;
            hex_mode = vt[i].hex; lz_blank = vt[i].lz;
            wait_fs();
            repeat (vt[i].slot * DIV + BLK) @(negedge clk);
            check($sformatf("vec%0d_seg", i), {25'h0, seg_a}, {25'h0, vt[i].seg_exp});
            check($sformatf("vec%0d_dp", i), {31'h0, dp_a}, {31'h0, vt[i].dp_exp});
            check($sformatf("vec%0d_an", i), {28'h0, an_a}, {28'h0, ~(4'b0001 << vt[i].slot)});
            check($sformatf("vec%0d_seg_hi", i), {25'h0, seg_b}, {25'h0, ~vt[i].seg_exp});
        end

        // Input change mid-frame must not tear the display
        digits = 16'h1111; dp_in = 4'h0; hex_mode = 1'b0; lz_blank = 1'b0;
        wait_fs();
        wait_fs();
        repeat (2 * DIV + BLK) @(negedge clk);
        digits = 16'h2222;
        @(negedge clk);
        check("tear_digit2", {25'h0, seg_a}, 32'h79);
        repeat (DIV) @(negedge clk);
        check("tear_digit3", {25'h0, seg_a}, 32'h79);
        wait_fs();
        repeat (BLK) @(negedge clk);
        check("tear_new_digit0", {25'h0, seg_a}, 32'h24);
        repeat (3 * DIV) @(negedge clk);
        check("tear_new_digit3", {25'h0, seg_a}, 32'h24);

        // Enable drop mid-slot on digit 1
        wait_fs();
        repeat (DIV + BLK + 1) @(negedge clk);
        check("en_pre_an", {28'h0, an_a}, 32'hD);
        en = 1'b0;
        @(negedge clk);
        check("en_off_an", {28'h0, an_a}, 32'hF);
        check("en_off_seg", {25'h0, seg_a}, 32'h7F);
        check("en_off_fs", {31'h0, fs_a}, 32'h0);
        repeat (4) @(negedge clk);
        en = 1'b1;
        @(negedge clk);
        check("en_restart_fs", {31'h0, fs_a}, 32'h1);
        check("en_restart_dead", {28'h0, an_a}, 32'hF);
        repeat (BLK) @(negedge clk);
        check("en_restart_digit0", {28'h0, an_a}, 32'hE);

        // Asynchronous reset in the middle of an active window
        wait_fs();
        repeat (BLK + 1) @(negedge clk);
        check("rst_pre_an_hi", {28'h0, an_b}, 32'h1);
        #2 rst = 1'b1;
        #1;
        check("rst_async_seg_hi", {25'h0, seg_b}, 32'h0);
        check("rst_async_dp_hi", {31'h0, dp_b}, 32'h0);
        check("rst_async_an_hi", {28'h0, an_b}, 32'h0);
        check("rst_async_an_lo", {28'h0, an_a}, 32'hF);
        @(negedge clk);
        rst = 1'b0;

        // Randomized run; the model checker compares every cycle
        off_left = 0;
        for (int cyc = 0; cyc < 2500; cyc++) begin
            @(negedge clk);
            if (off_left > 0) begin
                off_left--;
                if (off_left == 0) en = 1'b1;
            end else if ($urandom_range(0, 149) == 0) begin
                en = 1'b0;
                off_left = $urandom_range(1, 6);
            end
            if ($urandom_range(0, 29) == 0) begin
                for (int d = 0; d < N; d++)
                    digits[d*4 +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
                dp_in    = 4'($urandom_range(0, 15));
                hex_mode = 1'($urandom_range(0, 1));
                lz_blank = 1'($urandom_range(0, 1));
            end
            if (cyc == 1200) begin
                #3 rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end
        end
        en = 1'b1;
        repeat (4) @(negedge clk);
        chk_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ssd_tdm_driver.md
Name: ssd_tdm_driver

Overview:
Parametrised multi-digit seven-segment display driver. It time-division multiplexes N_DIGITS common-anode/cathode digits from one packed BCD/hex word. It adds hex glyphs, per-digit decimal points, leading-zero blanking, inter-digit dead time (anti-ghosting) and frame-coherent input capture. It sits between the counter/datapath and the board's seg/an pins and replaces the per-digit combinational decoders.

Parameters:
N_DIGITS, 4, number of multiplexed digits (>=1)
REFRESH_DIV, 100000, clk cycles per digit slot (> BLANK_CYCLES)
BLANK_CYCLES, 16, cycles at the start of each slot with all anodes inactive (0 allowed)
SEG_ACTIVE_LOW, 1, 1: segment lit = 0; 0: lit = 1
AN_ACTIVE_LOW, 1, 1: anode enabled = 0; 0: enabled = 1

Ports:
clk  in  1  system clock
rst  in  1  reset
en  in  1  display enable
digits  in  4*N_DIGITS  packed nibbles, digit i = digits[4i+3:4i], digit 0 = rightmost
dp_in  in  N_DIGITS  decimal point request per digit
hex_mode  in  1  1: values 10-15 show A,b,C,d,E,F; 0: values 10-15 show blank
lz_blank  in  1  1: suppress leading zeros
seg  out  7  segments, seg[6]=g … seg[0]=a
dp  out  1  decimal point segment (same polarity as seg)
an  out  N_DIGITS  digit enables, one-hot when active
frame_start  out  1  one-cycle pulse at start of each frame

Behaviour:
- One clock, clk; reset rst is asynchronous, active-high.
- Reset values:
  - cnt=0, idx=0, frame register=0.
  - seg and dp show all segments off (1111111 / 1 when SEG_ACTIVE_LOW).
  - an shows all digits inactive.
  - frame_start=0.
- Slot counter:
  - cnt runs 0..REFRESH_DIV-1, then wraps to 0.
  - On wrap, idx advances 0->1->…->N_DIGITS-1->0.
  - With N_DIGITS=1, idx stays 0.
- en=0:
  - cnt and idx forced to 0 each cycle.
  - Outputs forced off/inactive one cycle later.
  - frame_start=0.
- Frame capture:
  - When cnt==0 and idx==0, digits, dp_in, hex_mode and lz_blank are latched into the frame register. This also happens every cycle while en=0.
  - All display decisions use only the frame register, so an input change mid-frame never tears the display.
- frame_start is registered: high the cycle after cnt==0 && idx==0 && en.
- Dead time: while cnt < BLANK_CYCLES, the next-cycle an is all inactive and seg/dp are off.
- Active window, cnt >= BLANK_CYCLES: an enables only digit idx; seg = glyph(frame digit idx); dp = frame dp_in[idx].
- Latency: all outputs are registered, exactly 1 cycle after the cnt/idx state that selects them. No combinational path from inputs to pins.
- Glyphs, active-high gfedcba; inverted when SEG_ACTIVE_LOW=1:
  - 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110
  - 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111
  - A=1110111, b=1111100, C=0111001, d=1011110, E=1111001, F=1110001
  - hex_mode=0 and value>=10: blank.
- Leading-zero blanking (latched lz_blank=1):
  - Digit i is blanked if it and every digit above it (i+1..N_DIGITS-1) are 0.
  - Digit 0 is never blanked.
  - A blanked digit's dp is still shown if requested.
  - The anode still strobes, so brightness stays uniform.
- Reset mid-slot: all state clears immediately (async); the scan restarts at digit 0 after release.

Decomposition:
- Package ssd_pkg:
  - 16-entry active-high glyph constants and the GLYPH_BLANK constant.
  - Bit-position constants SEG_A..SEG_G.
  - Helper function for the clog2 of N_DIGITS, used for idx width (min 1 bit).
- One sub-module, ssd_glyph_rom: combinational, 4-bit value + hex_mode + blank -> 7-bit active-high pattern.
- Polarity inversion is done in the top-level output register.

Test Plan:
1. N_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2, digits=16'h1234, en=1 after reset. Required response:
   - an: 2 cycles 1111, then 6 cycles 1110 with seg=0011001 ("4").
   - Then an=1101 with seg=0110000 ("3"), and so on.
   - Wraps back to 1110 after 32 cycles; frame_start pulses every 32 cycles.
2. digits=16'h00A5, hex_mode=0, lz_blank=1. Required response:
   - Digits 3 and 2 blank (seg=1111111) with anodes still strobing.
   - Digit 1 blank (A is invalid in decimal mode); digit 0 = "5" (0010010).
   - Then set hex_mode=1: digits 3 and 2 stay blank, digit 1 = A (0001000) from the next frame.
3. digits=16'h0000, lz_blank=1, dp_in=4'b0100 -> only digit 0 shows "0" (1000000); digit 2 shows dp=0 with segments off.
4. Change digits 16'h1111 -> 16'h2222 while idx=2. Required response:
   - Digits 2 and 3 still show "1" for the rest of the frame.
   - All digits show "2" from the frame whose frame_start follows.
5. Drop en for 5 cycles mid-slot (idx=1), then re-raise it. Required response:
   - an=1111 and seg=1111111 one cycle after the drop.
   - After re-enable, the scan restarts at digit 0 with a full blank window.
6. Assert rst asynchronously mid-active-window, with SEG_ACTIVE_LOW=0 and AN_ACTIVE_LOW=0 -> outputs go immediately to seg=0000000, dp=0, an=0000.
